// File: rtl/mux8way_serializer_if.sv
// Bundle for mux8way_serializer: the eight lane inputs, load/ready handshake and serial word outputs.
// The design drives it through the slave modport; the producer/consumer side uses the master modport.
interface mux8way_serializer_if #(
  parameter int WIDTH = 16
);
  logic             load;
  logic             ready;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic [WIDTH-1:0] inC;
  logic [WIDTH-1:0] inD;
  logic [WIDTH-1:0] inE;
  logic [WIDTH-1:0] inF;
  logic [WIDTH-1:0] inG;
  logic [WIDTH-1:0] inH;
  logic [WIDTH-1:0] out;
  logic [2:0]       select;
  logic             valid;
  logic             busy;
  logic             done;
  logic             parity;

  modport master (
    output load, ready, inA, inB, inC, inD, inE, inF, inG, inH,
    input  out, select, valid, busy, done, parity
  );

  modport slave (
    input  load, ready, inA, inB, inC, inD, inE, inF, inG, inH,
    output out, select, valid, busy, done, parity
  );
endinterface

// File: rtl/mux8way_serializer.sv
// Captures eight lanes on load and offers them one per accepted transfer, lane A first.
// Define MUX8WAY_SERIALIZER_PARITY_EN to drive parity with the even-parity bit of out while valid.
module mux8way_serializer #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  mux8way_serializer_if.slave  bus
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  typedef logic [WIDTH-1:0] lane_t;

  state_t     state_q, state_d;
  logic [2:0] select_q, select_d;
  logic       done_q, done_d;
  lane_t      lanes_q [8];
  lane_t      lanes_d [8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      select_q <= 3'd0;
      done_q   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        lanes_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      done_q   <= done_d;
      lanes_q  <= lanes_d;
    end
  end

  // Lane registers only change on an accepted load in IDLE, so input churn mid-frame is invisible.
  always_comb begin
    state_d  = state_q;
    select_d = select_q;
    done_d   = 1'b0;
    lanes_d  = lanes_q;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          lanes_d[0] = bus.inA;
          lanes_d[1] = bus.inB;
          lanes_d[2] = bus.inC;
          lanes_d[3] = bus.inD;
          lanes_d[4] = bus.inE;
          lanes_d[5] = bus.inF;
          lanes_d[6] = bus.inG;
          lanes_d[7] = bus.inH;
          select_d   = 3'd0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (bus.ready) begin
          if (select_q == 3'd7) begin
            state_d  = IDLE;
            select_d = 3'd0;
            done_d   = 1'b1;
          end else begin
            select_d = select_q + 3'd1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        select_d = 3'd0;
      end
    endcase
  end

  always_comb begin
    bus.out   = '0;
    bus.valid = 1'b0;
    bus.busy  = 1'b0;
    if (state_q == SEND) begin
      bus.out   = lanes_q[select_q];
      bus.valid = 1'b1;
      bus.busy  = 1'b1;
    end
  end

  assign bus.select = select_q;
  assign bus.done   = done_q;

`ifdef MUX8WAY_SERIALIZER_PARITY_EN
  assign bus.parity = bus.valid & (^bus.out);
`else
  assign bus.parity = 1'b0;
`endif

endmodule

// File: tb/tb_mux8way_serializer.sv
// Directed bench for mux8way_serializer: plain frames, consumer stalls, held load with mid-frame input
// changes, asynchronous reset mid-frame and the parity output (honours MUX8WAY_SERIALIZER_PARITY_EN).
module tb_mux8way_serializer;

  logic clk;
  logic reset;
  int   num_checks;
  int   num_passed;

  mux8way_serializer_if #(.WIDTH(16)) bus ();

  mux8way_serializer #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_parity(input logic [15:0] value);
`ifdef MUX8WAY_SERIALIZER_PARITY_EN
    return ^value;
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end else begin
      num_passed++;
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] lanes [8], input logic load_value);
    bus.inA  = lanes[0];
    bus.inB  = lanes[1];
    bus.inC  = lanes[2];
    bus.inD  = lanes[3];
    bus.inE  = lanes[4];
    bus.inF  = lanes[5];
    bus.inG  = lanes[6];
    bus.inH  = lanes[7];
    bus.load = load_value;
  endtask

  task automatic check_idle(input string tag, input logic exp_done);
    checkOutput({tag, "_valid"},  32'(bus.valid),  32'd0);
    checkOutput({tag, "_busy"},   32'(bus.busy),   32'd0);
    checkOutput({tag, "_select"}, 32'(bus.select), 32'd0);
    checkOutput({tag, "_out"},    32'(bus.out),    32'd0);
    checkOutput({tag, "_parity"}, 32'(bus.parity), 32'd0);
    checkOutput({tag, "_done"},   32'(bus.done),   32'(exp_done));
  endtask

  // Walks a frame already in SEND; stalls ready at stall_sel for stall_len cycles and
  // optionally rewrites every input to new_val once lane change_at is on the bus.
  task automatic run_frame(input string tag, input logic [15:0] lanes [8], input int stall_sel,
                           input int stall_len, input int change_at, input logic [15:0] new_val,
                           input int exp_valid_cycles);
    int         exp_sel;
    int         valid_cycles;
    int         stall_left;
    bit         finished;
    logic [15:0] fill [8];
    exp_sel      = 0;
    valid_cycles = 0;
    stall_left   = stall_len;
    finished     = 1'b0;
    for (int i = 0; i < 8; i++) fill[i] = new_val;
    for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
      checkOutput({tag, "_valid"},  32'(bus.valid),  32'd1);
      checkOutput({tag, "_busy"},   32'(bus.busy),   32'd1);
      checkOutput({tag, "_select"}, 32'(bus.select), 32'(exp_sel));
      checkOutput({tag, "_out"},    32'(bus.out),    32'(lanes[exp_sel]));
      checkOutput({tag, "_parity"}, 32'(bus.parity), 32'(exp_parity(lanes[exp_sel])));
      checkOutput({tag, "_done"},   32'(bus.done),   32'd0);
      valid_cycles++;
      if (exp_sel == change_at) applyStimulus(fill, bus.load);
      if (exp_sel == stall_sel && stall_left > 0) begin
        bus.ready = 1'b0;
        stall_left--;
      end else begin
        bus.ready = 1'b1;
      end
      tick();
      if (bus.ready) begin
        if (exp_sel == 7) finished = 1'b1;
        else exp_sel++;
      end
    end
    checkOutput({tag, "_finished"},     32'(finished),     32'd1);
    checkOutput({tag, "_valid_cycles"}, 32'(valid_cycles), 32'(exp_valid_cycles));
    check_idle({tag, "_done_cycle"}, 1'b1);
    tick();
    checkOutput({tag, "_done_pulse_end"}, 32'(bus.done), 32'd0);
  endtask

  logic [15:0] seq_lanes [8];
  logic [15:0] ffff_lanes [8];
  logic [15:0] par_lanes [8];
  logic [15:0] zero_lanes [8];

  initial begin
    num_checks = 0;
    num_passed = 0;
    for (int i = 0; i < 8; i++) begin
      seq_lanes[i]  = 16'(i + 1);
      ffff_lanes[i] = 16'hFFFF;
      zero_lanes[i] = 16'h0000;
      par_lanes[i]  = 16'h00F0 + 16'(i);
    end
    par_lanes[0] = 16'h0007;
    par_lanes[1] = 16'h0003;

    reset     = 1'b1;
    bus.ready = 1'b0;
    applyStimulus(seq_lanes, 1'b1);
    tick();
    tick();
    check_idle("reset", 1'b0);

    // Plain frame, ready tied high.
    reset = 1'b0;
    applyStimulus(seq_lanes, 1'b0);
    tick();
    check_idle("idle_no_load", 1'b0);
    bus.ready = 1'b1;
    applyStimulus(seq_lanes, 1'b1);
    tick();
    bus.load = 1'b0;
    run_frame("plain", seq_lanes, -1, 0, -1, 16'h0, 8);
    check_idle("plain_after", 1'b0);

    // Consumer stalls three cycles on lane D.
    applyStimulus(seq_lanes, 1'b1);
    tick();
    bus.load = 1'b0;
    run_frame("stall", seq_lanes, 3, 3, -1, 16'h0, 11);

    // Load held high throughout, inputs go to FFFF mid-frame.
    applyStimulus(seq_lanes, 1'b1);
    tick();
    run_frame("held1", seq_lanes, -1, 0, 3, 16'hFFFF, 8);
    bus.load = 1'b0;
    run_frame("held2", ffff_lanes, -1, 0, -1, 16'h0, 8);

    // Parity vectors.
    applyStimulus(par_lanes, 1'b1);
    tick();
    bus.load = 1'b0;
    checkOutput("par_sel0", 32'(bus.parity), 32'(exp_parity(16'h0007)));
    run_frame("parity", par_lanes, -1, 0, -1, 16'h0, 8);

    // Asynchronous reset mid-frame, load asserted during reset.
    applyStimulus(seq_lanes, 1'b1);
    tick();
    bus.load = 1'b0;
    tick();
    tick();
    checkOutput("pre_reset_select", 32'(bus.select), 32'd2);
    bus.load = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    check_idle("async_reset", 1'b0);
    tick();
    check_idle("reset_held", 1'b0);
    reset    = 1'b0;
    bus.load = 1'b0;
    tick();
    check_idle("post_reset", 1'b0);
    tick();
    check_idle("post_reset2", 1'b0);
    applyStimulus(zero_lanes, 1'b1);
    tick();
    bus.load = 1'b0;
    run_frame("restart", zero_lanes, -1, 0, -1, 16'h0, 8);

    $display("%0d/%0d checks passed", num_passed, num_checks);
    $finish;
  end

endmodule
